// File: rtl/note_score_counter.sv
// note_score_counter: debounces seven piano keys, judges each new press against the
// expected note, and keeps saturating hit/miss tallies for the downstream display.
`default_nettype none

module note_score_counter #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int MAX_SCORE       = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] key_in,
    input  logic [2:0] expected_note,
    input  logic       expected_valid,
    input  logic       game_en,
    input  logic       clear,
    output logic [6:0] score,
    output logic [6:0] miss_count,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       next_req,
    output logic       busy
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]    SAT     = 7'(MAX_SCORE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_JUDGE   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic [6:0]    sync1, sync2, deb, deb_d;
    logic [DW-1:0] db_cnt [7];
    logic [6:0]    latched;
    logic [TW-1:0] timer;
    state_t        state;

    logic       press;
    logic       is_hit;

    // Two-flop synchroniser followed by a per-key stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 7; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 7; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= ~deb[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press  = |(deb & ~deb_d);
    assign is_hit = (expected_note <= 3'd6) && $onehot(latched) &&
                    (latched == (7'd1 << expected_note));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            latched    <= '0;
            score      <= '0;
            miss_count <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            next_req   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            next_req   <= 1'b0;
            if (!game_en) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (expected_valid) begin
                            state <= S_WAIT;
                            timer <= '0;
                            busy  <= 1'b1;
                        end else begin
                            busy  <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        busy <= 1'b1;
                        // Without a valid note the round is frozen: no timeout, no judging.
                        if (expected_valid) begin
                            if (press) begin
                                latched <= deb;
                                state   <= S_JUDGE;
                            end else if (timer == TO_LAST) begin
                                miss_pulse <= 1'b1;
                                next_req   <= 1'b1;
                                if (miss_count < SAT) miss_count <= miss_count + 1'b1;
                                state <= S_RELEASE;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    S_JUDGE: begin
                        busy     <= 1'b1;
                        next_req <= 1'b1;
                        if (is_hit) begin
                            hit_pulse <= 1'b1;
                            if (score < SAT) score <= score + 1'b1;
                        end else begin
                            miss_pulse <= 1'b1;
                            if (miss_count < SAT) miss_count <= miss_count + 1'b1;
                        end
                        state <= S_RELEASE;
                    end
                    S_RELEASE: begin
                        if (deb == 7'd0) begin
                            if (expected_valid) begin
                                state <= S_WAIT;
                                timer <= '0;
                                busy  <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            busy <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
            // Clear overrides any increment scheduled above in the same cycle.
            if (clear) begin
                score      <= '0;
                miss_count <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_note_score_counter.sv
// tb_note_score_counter: directed stimulus with a queue scoreboard of expected judgements.
`default_nettype none

module tb_note_score_counter;

    localparam int DB = 20;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] key_in = '0;
    logic [2:0] expected_note = 3'd3;
    logic       expected_valid = 1'b0;
    logic       game_en = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] score, miss_count;
    logic       hit_pulse, miss_pulse, next_req, busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       hit;
        logic [6:0] score;
        logic [6:0] miss;
    } exp_t;
    exp_t q[$];
    int   m_score = 0;
    int   m_miss  = 0;

    note_score_counter #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO),
        .MAX_SCORE      (99)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .expected_note (expected_note),
        .expected_valid(expected_valid),
        .game_en       (game_en),
        .clear         (clear),
        .score         (score),
        .miss_count    (miss_count),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .next_req      (next_req),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit hit, input bit clr);
        exp_t e;
        if (clr) begin
            m_score = 0;
            m_miss  = 0;
        end else if (hit) begin
            if (m_score < 99) m_score++;
        end else begin
            if (m_miss < 99) m_miss++;
        end
        e.hit   = hit;
        e.score = 7'(m_score);
        e.miss  = 7'(m_miss);
        q.push_back(e);
    endtask

    // Press a chord, hold it well past the debounce window, then release it fully.
    task automatic press(input logic [6:0] bits, input bit hit, input bit clr);
        push_exp(hit, clr);
        @(negedge clk);
        key_in = bits;
        clear  = clr;
        repeat (DB + 10) @(negedge clk);
        key_in = '0;
        repeat (DB + 10) @(negedge clk);
        clear = 1'b0;
        chk("judged", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && (hit_pulse || miss_pulse || next_req)) begin
            chk("pulse_expected", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("hit_pulse", hit_pulse, e.hit);
                chk("miss_pulse", miss_pulse, !e.hit);
                chk("next_req", next_req, 1);
                chk("score", score, e.score);
                chk("miss_count", miss_count, e.miss);
            end
        end
    end

    initial begin
        int n;
        // Reset state
        #1;
        chk("rst_score", score, 0);
        chk("rst_miss", miss_count, 0);
        chk("rst_pulses", {hit_pulse, miss_pulse, next_req}, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Correct note, wrong note, chord
        game_en = 1'b1;
        expected_valid = 1'b1;
        expected_note = 3'd3;
        press(7'b0001000, 1'b1, 1'b0);
        chk("score_after_hit", score, 1);
        press(7'b0000100, 1'b0, 1'b0);
        chk("score_kept", score, 1);
        chk("miss_after_wrong", miss_count, 1);
        press(7'b0011000, 1'b0, 1'b0);
        chk("miss_after_chord", miss_count, 2);

        // Bounce shorter than the debounce window; round frozen meanwhile
        expected_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_in[3] = ~key_in[3];
            repeat (DB / 2) @(negedge clk);
        end
        key_in = '0;
        repeat (DB + 10) @(negedge clk);
        chk("bounce_no_event", q.size(), 0);
        chk("bounce_score", score, 1);
        chk("bounce_miss", miss_count, 2);

        game_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Timeout: miss must appear exactly TO cycles after WAIT is entered
        expected_valid = 1'b1;
        push_exp(1'b0, 1'b0);
        game_en = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("busy_entered", busy, 1);
        n = 0;
        while (!miss_pulse && n < 3 * TO) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle", n, TO);
        chk("timeout_miss", miss_count, 3);

        // Saturation
        for (int i = 0; i < 101; i++) press(7'b0001000, 1'b1, 1'b0);
        chk("sat_score", score, 99);

        // Clear held across a hit wins over the increment
        press(7'b0001000, 1'b1, 1'b1);
        chk("clear_score", score, 0);
        chk("clear_miss", miss_count, 0);
        press(7'b0001000, 1'b1, 1'b0);
        chk("after_clear", score, 1);

        // Asynchronous reset while the press is being judged
        @(negedge clk);
        key_in = 7'b0001000;
        repeat (DB + 3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("amid_rst_score", score, 0);
        chk("amid_rst_miss", miss_count, 0);
        chk("amid_rst_pulses", {hit_pulse, miss_pulse, next_req}, 0);
        chk("amid_rst_busy", busy, 0);
        @(negedge clk);
        key_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (DB + 10) @(negedge clk);
        chk("post_rst_score", score, 0);
        chk("final_queue", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/note_score_counter.md
Name: note_score_counter

Overview:
Scoring stage for piano practice mode. Debounces the seven piano key inputs and detects new key presses. Judges each press against the currently expected note and keeps a saturating 0-99 hit score. `score` drives the `counter_value` input of the two-digit seven-segment display stage directly downstream.

Parameters:
- DEBOUNCE_CYCLES, 20000, consecutive stable cycles before a key's debounced level changes.
- TIMEOUT_CYCLES, 50000000, cycles allowed in WAIT before the note is judged a miss.
- MAX_SCORE, 99, saturation value for `score` and `miss_count`; must be ≤127.

Ports:
- clk, input, 1, system clock; all logic rising-edge.
- rst, input, 1, asynchronous active-high reset.
- key_in, input, 7, raw piano keys; bit i = note i; asynchronous to clk; 2-flop synchronised internally.
- expected_note, input, 3, index 0-6 of note to play; values 7 are treated as "no valid key matches".
- expected_valid, input, 1, expected_note is meaningful.
- game_en, input, 1, scoring enabled.
- clear, input, 1, synchronous clear of `score` and `miss_count`.
- score, output, 7, hit count 0..MAX_SCORE; feeds display counter_value.
- miss_count, output, 7, miss count 0..MAX_SCORE.
- hit_pulse, output, 1, one-cycle pulse on a correct judgement.
- miss_pulse, output, 1, one-cycle pulse on a wrong press or timeout.
- next_req, output, 1, one-cycle pulse asking the upstream melody source to advance the note; asserted together with `hit_pulse` or `miss_pulse`.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset (async): `score`=0, `miss_count`=0, all pulses 0, `busy`=0, state IDLE, timer 0, debounced keys 0, synchronisers 0.
- Debounce: one counter per key.
  - The counter runs while the synchronised level differs from the debounced level.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Any agreement between the two levels clears the counter.
  - Glitches shorter than DEBOUNCE_CYCLES produce no change.
- Press event: a cycle in which any debounced bit rises. The event vector is the full debounced vector in that cycle.
- FSM states: IDLE, WAIT, JUDGE, RELEASE.
  - Any state with `game_en`=0: go to IDLE next cycle. `score` and `miss_count` are held; no pulses.
  - IDLE: if `game_en` && `expected_valid`, go to WAIT with timer=0.
  - WAIT, press event: latch the vector, go to JUDGE.
  - WAIT, no press and timer==TIMEOUT_CYCLES-1: assert `miss_pulse` and `next_req` that cycle, increment `miss_count`, go to RELEASE.
  - WAIT, otherwise: increment timer.
  - WAIT with `expected_valid`=0: timer holds, presses are ignored.
  - JUDGE (exactly one cycle): hit when the latched vector is exactly one-hot AND equals 1<<`expected_note` with `expected_note`≤6.
    - Hit: `hit_pulse`=1, `score`+1.
    - Otherwise: `miss_pulse`=1, `miss_count`+1.
    - `next_req`=1 in both cases.
    - Then go to RELEASE.
  - RELEASE: stay until all debounced keys are 0. Then go to WAIT (timer=0) if `expected_valid`, else IDLE.
- Latency: the JUDGE-cycle pulses appear on the registered outputs 2 cycles after the debounced rising edge (edge cycle, JUDGE cycle). Counters update on the same edge that the pulses assert.
- Arithmetic: increments saturate at MAX_SCORE. At saturation the pulse still fires but the count holds.
- `clear` has priority over an increment in the same cycle: the result is 0. `clear` does not change FSM state or pulses.
- All outputs are registered. Pulses are exactly one cycle wide.
- A new press during RELEASE is not judged. Held keys never retrigger.

Test Plan:
- Reset mid-JUDGE: assert `rst` async → all outputs 0 immediately, state IDLE, no pulse after release.
- `game_en`=1, `expected_valid`=1, `expected_note`=3; hold `key_in`=0001000 for DEBOUNCE_CYCLES+10 → single `hit_pulse` and `next_req`, `score`=1; no further pulse until release and re-press.
- `expected_note`=3:
  - Press 0000100 (note 2) → `miss_pulse`, `miss_count`=1, `score` unchanged.
  - Press 0011000 simultaneously → miss.
- Bounce: toggle key 3 every DEBOUNCE_CYCLES/2 cycles for 10 toggles → no events.
- No press for TIMEOUT_CYCLES (reduced to 100 in bench) → `miss_pulse` and `next_req` exactly at cycle 100 of WAIT.
- Saturation: 101 correct hits → `score` stays 99, `hit_pulse` still fires. `clear` coincident with a hit → `score`=0.
